// File: rtl/fnd_scan_driver_if.sv
// Bus between the datapath and the FND scan driver.
//   data   : packed 4-bit digit codes, digit 0 in the low nibble
//   dp     : decimal point request per digit, 1 = lit
//   load   : one-cycle request to capture data/dp at the next frame boundary
//   blank  : level, 1 = whole display dark
//   fnd    : segments g..a, active-low
//   fnd_dp : decimal point segment, active-low
//   com    : digit common enables
//   frame  : one-cycle pulse when the scan wraps to digit 0
interface fnd_scan_driver_if #(
  parameter int unsigned NUM_DIGITS = 6
) ();
  logic [4*NUM_DIGITS-1:0] data;
  logic [NUM_DIGITS-1:0]   dp;
  logic                    load;
  logic                    blank;
  logic [6:0]              fnd;
  logic                    fnd_dp;
  logic [NUM_DIGITS-1:0]   com;
  logic                    frame;

  modport master (
    output data, dp, load, blank,
    input  fnd, fnd_dp, com, frame
  );

  modport slave (
    input  data, dp, load, blank,
    output fnd, fnd_dp, com, frame
  );
endinterface

// File: rtl/fnd_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver.
// Captures digit codes into a shadow register at frame boundaries and scans
// one digit per slot, with decode, decimal point, leading-zero blanking and
// an anti-ghosting blank window at the start of every slot.
//   i_Clk   : system clock
//   i_Reset : asynchronous active-high reset
//   bus     : slave side of fnd_scan_driver_if (inputs data/dp/load/blank,
//             registered outputs fnd/fnd_dp/com/frame)
module fnd_scan_driver #(
  parameter int unsigned NUM_DIGITS     = 6,
  parameter int unsigned CLK_DIV        = 50000,
  parameter int unsigned BLANK_CYCLES   = 500,
  parameter int unsigned HEX_EN         = 0,
  parameter int unsigned LZ_BLANK       = 1,
  parameter int unsigned COM_ACTIVE_LOW = 1
) (
  input  logic            i_Clk,
  input  logic            i_Reset,
  fnd_scan_driver_if.slave bus
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] COM_OFF =
    (COM_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [PW-1:0]                presc;
  logic [IW-1:0]                idx;
  logic                         load_pend;
  logic [NUM_DIGITS-1:0][3:0]   shadow_data;
  logic [NUM_DIGITS-1:0]        shadow_dp;

  logic                         slot_end_c;
  logic                         frame_end_c;
  logic                         show_c;
  logic [NUM_DIGITS-1:0]        lz_mask_c;
  logic [NUM_DIGITS-1:0]        onehot_c;
  logic [6:0]                   seg_c;

  // Code to active-low g..a segments; codes above 9 are dark unless HEX_EN.
  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1011000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0011000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    if (code > 4'h9 && HEX_EN == 0) s = 7'h7f;
    return s;
  endfunction

  // Slot and frame boundary strobes.
  always_comb begin
    slot_end_c  = (presc == PRESC_LAST);
    frame_end_c = slot_end_c && (idx == IDX_LAST);
  end

  // Leading-zero mask: a digit is blank when it and every digit above it
  // are zero with no decimal point; digit 0 is always shown.
  always_comb begin
    logic lead;
    lead      = 1'b1;
    lz_mask_c = '0;
    if (LZ_BLANK != 0) begin
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
        lead = lead && (shadow_data[IW'(k)] == 4'h0) && !shadow_dp[IW'(k)];
        lz_mask_c[IW'(k)] = lead;
      end
    end
  end

  // Slot content for the digit currently selected.
  always_comb begin
    onehot_c      = '0;
    onehot_c[idx] = 1'b1;
    show_c        = !bus.blank && (presc >= BLANK_END);
    seg_c         = lz_mask_c[idx] ? 7'h7f : decode(shadow_data[idx]);
  end

  // Prescaler, digit index and frame-synchronous shadow capture.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      presc       <= '0;
      idx         <= '0;
      load_pend   <= 1'b0;
      shadow_data <= '0;
      shadow_dp   <= '0;
    end else begin
      presc <= slot_end_c ? '0 : presc + PW'(1);
      if (slot_end_c) idx <= frame_end_c ? '0 : idx + IW'(1);
      if (frame_end_c) begin
        // A load arriving in the boundary cycle itself is honoured here.
        load_pend <= 1'b0;
        if (load_pend || bus.load) begin
          shadow_data <= bus.data;
          shadow_dp   <= bus.dp;
        end
      end else if (bus.load) begin
        load_pend <= 1'b1;
      end
    end
  end

  // Registered display outputs.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      bus.fnd    <= 7'h7f;
      bus.fnd_dp <= 1'b1;
      bus.com    <= COM_OFF;
      bus.frame  <= 1'b0;
    end else begin
      bus.frame <= frame_end_c;
      if (show_c) begin
        bus.fnd    <= seg_c;
        bus.fnd_dp <= ~shadow_dp[idx];
        bus.com    <= (COM_ACTIVE_LOW != 0) ? ~onehot_c : onehot_c;
      end else begin
        bus.fnd    <= 7'h7f;
        bus.fnd_dp <= 1'b1;
        bus.com    <= COM_OFF;
      end
    end
  end

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Directed bench for fnd_scan_driver: two instances share the stimulus,
// dut_a (HEX_EN=0, LZ_BLANK=1) and dut_b (HEX_EN=1, LZ_BLANK=0),
// both with 4 digits, 8 cycles per slot and a 2-cycle blank window.
module tb_fnd_scan_driver;

  logic        clk;
  logic        rst;
  logic [15:0] data;
  logic [3:0]  dp;
  logic        load;
  logic        blank;

  int n_err = 0;
  int n_chk = 0;

  logic [6:0] seg_a [4];
  logic       dp_a  [4];
  logic [6:0] seg_b [4];
  logic       dp_b  [4];

  fnd_scan_driver_if #(.NUM_DIGITS(4)) ifa ();
  fnd_scan_driver_if #(.NUM_DIGITS(4)) ifb ();

  assign ifa.data  = data;
  assign ifa.dp    = dp;
  assign ifa.load  = load;
  assign ifa.blank = blank;
  assign ifb.data  = data;
  assign ifb.dp    = dp;
  assign ifb.load  = load;
  assign ifb.blank = blank;

  fnd_scan_driver #(
    .NUM_DIGITS(4), .CLK_DIV(8), .BLANK_CYCLES(2),
    .HEX_EN(0), .LZ_BLANK(1), .COM_ACTIVE_LOW(1)
  ) dut_a (
    .i_Clk(clk), .i_Reset(rst), .bus(ifa)
  );

  fnd_scan_driver #(
    .NUM_DIGITS(4), .CLK_DIV(8), .BLANK_CYCLES(2),
    .HEX_EN(1), .LZ_BLANK(0), .COM_ACTIVE_LOW(1)
  ) dut_b (
    .i_Clk(clk), .i_Reset(rst), .bus(ifb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance to the next negedge that shows o_Frame, bounded.
  task automatic sync_frame();
    int t;
    t = 0;
    @(negedge clk);
    while (!ifa.frame && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("frame_seen", 32'(ifa.frame), 32'd1);
  endtask

  // From a frame negedge, sample the middle of each digit slot of one frame.
  task automatic read_frame();
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if ((k - 1) % 8 == 4) begin
        seg_a[(k - 1) / 8] = ifa.fnd;
        dp_a[(k - 1) / 8]  = ifa.fnd_dp;
        seg_b[(k - 1) / 8] = ifb.fnd;
        dp_b[(k - 1) / 8]  = ifb.fnd_dp;
      end
    end
    check("frame_period", 32'(ifa.frame), 32'd1);
  endtask

  // exp_seg packs {d3,d2,d1,d0}; exp_dp holds the expected active-low o_DP.
  task automatic check_digits(input string tag, input bit use_b,
                              input logic [27:0] exp_seg, input logic [3:0] exp_dp);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("%s_seg%0d", tag, d),
            32'(use_b ? seg_b[d] : seg_a[d]), 32'(exp_seg[d*7 +: 7]));
      check($sformatf("%s_dp%0d", tag, d),
            32'(use_b ? dp_b[d] : dp_a[d]), 32'(exp_dp[d]));
    end
  endtask

  initial begin
    int slot;
    int p;
    int n;
    rst   = 1'b1;
    data  = 16'h0000;
    dp    = 4'h0;
    load  = 1'b0;
    blank = 1'b0;

    // Reset values.
    step(2);
    check("rst_fnd", 32'(ifa.fnd), 32'h7f);
    check("rst_dp", 32'(ifa.fnd_dp), 32'd1);
    check("rst_com", 32'(ifa.com), 32'hf);
    check("rst_frame", 32'(ifa.frame), 32'd0);
    rst = 1'b0;

    // Scan order, blank window and frame period from an empty shadow.
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      slot = (k - 1) / 8;
      p    = (k - 1) % 8;
      check($sformatf("scan_com_k%0d", k), 32'(ifa.com),
            (p < 2) ? 32'hf : 32'(4'hf & ~(4'b1 << slot)));
      if (p >= 2) begin
        check($sformatf("scan_fnd_a_k%0d", k), 32'(ifa.fnd), (slot == 0) ? 32'h40 : 32'h7f);
        check($sformatf("scan_fnd_b_k%0d", k), 32'(ifb.fnd), 32'h40);
      end
      if (k == 31) check("scan_frame_low", 32'(ifa.frame), 32'd0);
      if (k == 32) check("scan_frame_high", 32'(ifa.frame), 32'd1);
    end

    // Mid-frame load: old content until the next boundary.
    step(9);
    data = 16'h1234;
    dp   = 4'b0100;
    load = 1'b1;
    step(1);
    load = 1'b0;
    step(11);
    check("hold_old_fnd_b", 32'(ifb.fnd), 32'h40);
    check("hold_old_dp_b", 32'(ifb.fnd_dp), 32'd1);
    check("hold_old_com", 32'(ifa.com), 32'b1011);
    sync_frame();
    read_frame();
    check_digits("d1234", 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1011);

    // Leading-zero blanking, then a decimal point stops it.
    data = 16'h0070;
    dp   = 4'b0000;
    load = 1'b1;
    step(1);
    load = 1'b0;
    sync_frame();
    read_frame();
    check_digits("lz_a", 1'b0, {7'h7f, 7'h7f, 7'h58, 7'h40}, 4'b1111);
    check_digits("lz_b", 1'b1, {7'h40, 7'h40, 7'h58, 7'h40}, 4'b1111);
    dp   = 4'b1000;
    load = 1'b1;
    step(1);
    load = 1'b0;
    sync_frame();
    read_frame();
    check_digits("lzdp_a", 1'b0, {7'h40, 7'h40, 7'h58, 7'h40}, 4'b0111);

    // Hex codes: dark without HEX_EN, letters with it.
    data = 16'hABCF;
    dp   = 4'b0000;
    load = 1'b1;
    step(1);
    load = 1'b0;
    sync_frame();
    read_frame();
    check_digits("hex_a", 1'b0, {7'h7f, 7'h7f, 7'h7f, 7'h7f}, 4'b1111);
    check_digits("hex_b", 1'b1, {7'h08, 7'h03, 7'h46, 7'h0e}, 4'b1111);

    // Load held high exactly in the boundary cycle.
    step(31);
    data = 16'h0005;
    load = 1'b1;
    step(1);
    check("coinc_frame", 32'(ifa.frame), 32'd1);
    load = 1'b0;
    read_frame();
    check_digits("coinc_a", 1'b0, {7'h7f, 7'h7f, 7'h7f, 7'h12}, 4'b1111);
    check_digits("coinc_b", 1'b1, {7'h40, 7'h40, 7'h40, 7'h12}, 4'b1111);

    // i_Blank mid-slot darkens next cycle without disturbing the frame rate.
    step(5);
    check("pre_blank_com", 32'(ifa.com), 32'he);
    blank = 1'b1;
    step(1);
    check("blank_com", 32'(ifa.com), 32'hf);
    check("blank_fnd", 32'(ifa.fnd), 32'h7f);
    n = 6;
    while (!ifa.frame && n < 100) begin
      step(1);
      n++;
    end
    check("blank_frame_spacing", 32'(n), 32'd32);
    blank = 1'b0;

    // Reset in the digit-2 slot.
    step(20);
    check("pre_rst_com", 32'(ifa.com), 32'b1011);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_fnd", 32'(ifa.fnd), 32'h7f);
    check("mid_rst_com_a", 32'(ifa.com), 32'hf);
    check("mid_rst_com_b", 32'(ifb.com), 32'hf);
    check("mid_rst_dp", 32'(ifa.fnd_dp), 32'd1);
    step(2);
    rst = 1'b0;
    step(2);
    check("post_rst_blankwin", 32'(ifb.com), 32'hf);
    step(1);
    check("post_rst_com_b", 32'(ifb.com), 32'he);
    check("post_rst_fnd_b", 32'(ifb.fnd), 32'h40);
    check("post_rst_fnd_a", 32'(ifa.fnd), 32'h40);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
